// File: rtl/palette_ram.sv
`default_nettype none
// ============================================================================
// Module   : palette_ram
// Brief    : Palette/line memory with separate write and read ports, a
//            hardware clear sequencer, and a read latency of 1 or 2 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module palette_ram #(
  parameter int                    DEPTH        = 16,
  parameter int                    DATA_WIDTH   = 12,
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam logic [ADDR_WIDTH:0]   c_depth = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_last  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;

  logic                    w_wr_in_range;
  logic                    w_rd_in_range;
  logic                    w_wr_accept;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_waddr;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;
  logic [DATA_WIDTH-1:0]   w_rd_value;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    s1_valid_q;
  logic [DATA_WIDTH-1:0]   s1_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // A clear request restarts the sweep from entry 0 even mid-clear.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_req) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == c_last) begin
          state_d    = S_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = S_CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  assign busy     = (state_q == S_CLEAR);
  assign wr_ready = ~busy;

  assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
  assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);
  assign w_wr_accept   = wr_en & wr_ready & w_wr_in_range;

  assign w_mem_we    = busy | w_wr_accept;
  assign w_mem_waddr = busy ? clr_addr_q : wr_addr;
  assign w_mem_wdata = busy ? INIT_VALUE : wr_data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Reads during a clear report the fill value; same-address writes bypass.
  always_comb begin
    w_rd_value = '0;
    if (!w_rd_in_range) begin
      w_rd_value = '0;
    end else if (busy) begin
      w_rd_value = INIT_VALUE;
    end else if (w_wr_accept && (wr_addr == rd_addr)) begin
      w_rd_value = wr_data;
    end else begin
      w_rd_value = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      if (rd_en) begin
        s1_data_q <= w_rd_value;
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign rd_data  = s1_data_q;
      assign rd_valid = s1_valid_q;
    end else begin : g_lat2
      logic                  s2_valid_q;
      logic [DATA_WIDTH-1:0] s2_data_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            s2_data_q <= s1_data_q;
          end
        end
      end

      assign rd_data  = s2_data_q;
      assign rd_valid = s2_valid_q;
    end
  endgenerate

endmodule
`default_nettype wire
